channel_crossbar: RTL

- Parametrised physical-to-logical channel crossbar for the ADC/DSP data path, with an optional sign inversion on each logical channel.
- The host programs a shadow map one entry at a time, then commits it. The commit takes effect only on a frame boundary, so no frame ever carries a mix of old and new mapping.
- Sits between the ADC sample stream and the downstream per-channel DSP. Runs entirely in the sample clock domain; crossing from the register domain is done upstream.

---
 rtl/channel_crossbar.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/channel_crossbar.sv
// Physical-to-logical channel crossbar with per-channel saturating negation.
// The shadow map is copied to the active map only on a frame boundary after a commit.
module channel_crossbar #(
  parameter int NUM_CHANNELS  = 8,
  parameter int CHANNEL_WIDTH = 16,
  localparam int SEL_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                    clk,
  input  logic                                    rstN,
  input  logic                                    mapWrStrobe,
  input  logic [SEL_WIDTH-1:0]                    mapWrAddr,
  input  logic [SEL_WIDTH-1:0]                    mapWrSel,
  input  logic                                    mapWrNegate,
  input  logic                                    mapCommit,
  input  logic                                    frameStart,
  output logic                                    mapPending,
  output logic                                    mapError,
  input  logic                                    errorClear,
  input  logic [SEL_WIDTH-1:0]                    mapRdAddr,
  output logic [SEL_WIDTH-1:0]                    mapRdSel,
  output logic                                    mapRdNegate,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   physicalData,
  input  logic [NUM_CHANNELS-1:0]                 physicalValid,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   logicalData,
  output logic [NUM_CHANNELS-1:0]                 logicalValid
);

  localparam logic [SEL_WIDTH:0]       NUM_CH_L = (SEL_WIDTH+1)'(NUM_CHANNELS);
  localparam logic [CHANNEL_WIDTH-1:0] MIN_VAL  = {1'b1, {(CHANNEL_WIDTH-1){1'b0}}};
  localparam logic [CHANNEL_WIDTH-1:0] MAX_VAL  = {1'b0, {(CHANNEL_WIDTH-1){1'b1}}};
  localparam logic [CHANNEL_WIDTH-1:0] ONE_VAL  = {{(CHANNEL_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic inRange(input logic [SEL_WIDTH-1:0] idx);
    return ({1'b0, idx} < NUM_CH_L);
  endfunction

  // Two's-complement negation; the most negative value saturates to the most positive.
  function automatic logic [CHANNEL_WIDTH-1:0] satNegate(input logic [CHANNEL_WIDTH-1:0] x);
    logic [CHANNEL_WIDTH-1:0] r;
    if (x == MIN_VAL) begin
      r = MAX_VAL;
    end else begin
      r = (~x) + ONE_VAL;
    end
    return r;
  endfunction

  logic [SEL_WIDTH-1:0]     shadowSel_r     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  shadowNeg_r;
  logic [SEL_WIDTH-1:0]     shadowSelNext_s [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  shadowNegNext_s;
  logic [SEL_WIDTH-1:0]     activeSel_r     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  activeNeg_r;
  logic [SEL_WIDTH-1:0]     effSel_s        [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  effNeg_s;
  logic [CHANNEL_WIDTH-1:0] physArr_s       [NUM_CHANNELS];
  logic [CHANNEL_WIDTH-1:0] stage1DataNext_s[NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  stage1ValidNext_s;
  logic [CHANNEL_WIDTH-1:0] stage1Data_r    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  stage1Valid_r;
  logic [NUM_CHANNELS-1:0]  stage1Neg_r;

  logic                                  mapPending_r;
  logic                                  mapError_r;
  logic [SEL_WIDTH-1:0]                  mapRdSel_r;
  logic                                  mapRdNegate_r;
  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] logicalData_r;
  logic [NUM_CHANNELS-1:0]               logicalValid_r;

  logic wrOk_s;
  logic errSet_s;
  logic swap_s;

  assign wrOk_s   = mapWrStrobe & inRange(mapWrAddr);
  assign errSet_s = mapWrStrobe & ~inRange(mapWrAddr);
  assign swap_s   = mapPending_r & frameStart;

  // Shadow next-state; the effective map already reflects a swap on its edge so the
  // frameStart sample is the first to use the new mapping.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (wrOk_s && (mapWrAddr == SEL_WIDTH'(i))) begin
        shadowSelNext_s[i] = mapWrSel;
        shadowNegNext_s[i] = mapWrNegate;
      end else begin
        shadowSelNext_s[i] = shadowSel_r[i];
        shadowNegNext_s[i] = shadowNeg_r[i];
      end
      if (swap_s) begin
        effSel_s[i] = shadowSelNext_s[i];
        effNeg_s[i] = shadowNegNext_s[i];
      end else begin
        effSel_s[i] = activeSel_r[i];
        effNeg_s[i] = activeNeg_r[i];
      end
    end
  end

  // Stage-1 source selection; out-of-range selects yield zero data and no valid.
  always_comb begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      physArr_s[k] = physicalData[k*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (inRange(effSel_s[i])) begin
        stage1DataNext_s[i]  = physArr_s[effSel_s[i]];
        stage1ValidNext_s[i] = physicalValid[effSel_s[i]];
      end else begin
        stage1DataNext_s[i]  = {CHANNEL_WIDTH{1'b0}};
        stage1ValidNext_s[i] = 1'b0;
      end
    end
  end

  // Map state: shadow, active, commit pending and sticky error.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadowSel_r[i] <= SEL_WIDTH'(i);
        activeSel_r[i] <= SEL_WIDTH'(i);
      end
      shadowNeg_r  <= {NUM_CHANNELS{1'b0}};
      activeNeg_r  <= {NUM_CHANNELS{1'b0}};
      mapPending_r <= 1'b0;
      mapError_r   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadowSel_r[i] <= shadowSelNext_s[i];
        activeSel_r[i] <= effSel_s[i];
      end
      shadowNeg_r <= shadowNegNext_s;
      activeNeg_r <= effNeg_s;
      if (swap_s) begin
        mapPending_r <= 1'b0;
      end else if (mapCommit) begin
        mapPending_r <= 1'b1;
      end else begin
        mapPending_r <= mapPending_r;
      end
      if (errSet_s) begin
        mapError_r <= 1'b1;
      end else if (errorClear) begin
        mapError_r <= 1'b0;
      end else begin
        mapError_r <= mapError_r;
      end
    end
  end

  // Active-map readback with one cycle of latency.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      mapRdSel_r    <= {SEL_WIDTH{1'b0}};
      mapRdNegate_r <= 1'b0;
    end else if (inRange(mapRdAddr)) begin
      mapRdSel_r    <= activeSel_r[mapRdAddr];
      mapRdNegate_r <= activeNeg_r[mapRdAddr];
    end else begin
      mapRdSel_r    <= {SEL_WIDTH{1'b0}};
      mapRdNegate_r <= 1'b0;
    end
  end

  // Two-stage datapath: select then negate.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        stage1Data_r[i] <= {CHANNEL_WIDTH{1'b0}};
      end
      stage1Valid_r  <= {NUM_CHANNELS{1'b0}};
      stage1Neg_r    <= {NUM_CHANNELS{1'b0}};
      logicalData_r  <= {(NUM_CHANNELS*CHANNEL_WIDTH){1'b0}};
      logicalValid_r <= {NUM_CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        stage1Data_r[i] <= stage1DataNext_s[i];
        logicalData_r[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] <=
          stage1Neg_r[i] ? satNegate(stage1Data_r[i]) : stage1Data_r[i];
      end
      stage1Valid_r  <= stage1ValidNext_s;
      stage1Neg_r    <= effNeg_s;
      logicalValid_r <= stage1Valid_r;
    end
  end

  assign mapPending   = mapPending_r;
  assign mapError     = mapError_r;
  assign mapRdSel     = mapRdSel_r;
  assign mapRdNegate  = mapRdNegate_r;
  assign logicalData  = logicalData_r;
  assign logicalValid = logicalValid_r;

endmodule
